// File: rtl/nn_dense_seq.sv
// Time-multiplexed dense layer: buffers one input vector, runs one MAC per weight
// against external synchronous ROMs, and streams one scaled/saturated result per neuron.
module nn_dense_seq #(
  parameter int unsigned IN_SIZE  = 13,
  parameter int unsigned OUT_SIZE = 16,
  parameter int unsigned IN_W     = 8,
  parameter int unsigned W_W      = 8,
  parameter int unsigned ACC_W    = 24,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned SHIFT    = 7,
  parameter int unsigned RELU     = 1,
  localparam int unsigned WA_W = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
  localparam int unsigned O_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  output logic [WA_W-1:0]         w_addr,
  input  logic signed [W_W-1:0]   w_data,
  output logic [O_W-1:0]          b_addr,
  input  logic signed [ACC_W-1:0] b_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [O_W-1:0]          out_index,
  output logic                    out_last,
  output logic                    busy
);

  localparam int unsigned IX_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int unsigned CNT_W  = $clog2(IN_SIZE + 1);
  localparam int unsigned PROD_W = IN_W + W_W;
  localparam int unsigned X_W    = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [X_W-1:0] SAT_MAX = {{(X_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [X_W-1:0] SAT_MIN = {{(X_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  typedef enum logic [1:0] {S_LOAD, S_MAC, S_OUT} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        i_q, i_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [O_W-1:0]          o_q, o_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;
  logic [O_W-1:0]          out_index_q, out_index_d;
  logic                    out_last_q, out_last_d;
  logic                    busy_q, busy_d;
  logic [WA_W-1:0]         w_addr_q, w_addr_d;
  logic [O_W-1:0]          b_addr_q, b_addr_d;
  logic signed [IN_W-1:0]  vec_q [IN_SIZE];
  logic signed [IN_W-1:0]  vec_d [IN_SIZE];

  logic signed [IN_W-1:0]   mac_x;
  logic signed [PROD_W-1:0] mac_p;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [ACC_W-1:0]  acc_sh;
  logic signed [X_W-1:0]    res_x;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    cnt_d       = cnt_q;
    o_d         = o_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    w_addr_d    = w_addr_q;
    b_addr_d    = b_addr_q;
    vec_d       = vec_q;

    // Accumulate step: the weight returned now belongs to element cnt-1; bias seeds the first step.
    mac_x   = vec_q[IX_W'(cnt_q - CNT_W'(1))];
    mac_p   = PROD_W'(mac_x) * PROD_W'(w_data);
    mac_sum = ((cnt_q == CNT_W'(1)) ? b_data : acc_q) + ACC_W'(mac_p);

    acc_sh = mac_sum >>> SHIFT;
    res_x  = X_W'(acc_sh);
    if (RELU != 0 && res_x[X_W-1]) res_x = '0;
    if (res_x > SAT_MAX) res_x = SAT_MAX;
    else if (res_x < SAT_MIN) res_x = SAT_MIN;

    case (state_q)
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          vec_d[IX_W'(i_q)] = in_data;
          if (in_last) begin
            for (int unsigned j = 0; j < IN_SIZE; j++) begin
              if (CNT_W'(j) > i_q) vec_d[IX_W'(j)] = '0;
            end
          end
          if (in_last || i_q == CNT_W'(IN_SIZE - 1)) begin
            state_d    = S_MAC;
            i_d        = '0;
            cnt_d      = '0;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            w_addr_d   = WA_W'(32'(o_q) * IN_SIZE);
            b_addr_d   = o_q;
          end else begin
            i_d = i_q + CNT_W'(1);
          end
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_W'(IN_SIZE - 1)) w_addr_d = w_addr_q + WA_W'(1);
        if (cnt_q != '0) acc_d = mac_sum;
        if (cnt_q == CNT_W'(IN_SIZE)) begin
          state_d     = S_OUT;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = OUT_W'(res_x);
          out_index_d = o_q;
          out_last_d  = (o_q == O_W'(OUT_SIZE - 1));
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (o_q == O_W'(OUT_SIZE - 1)) begin
            state_d    = S_LOAD;
            o_d        = '0;
            i_d        = '0;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
          end else begin
            o_d      = o_q + O_W'(1);
            state_d  = S_MAC;
            cnt_d    = '0;
            w_addr_d = WA_W'(32'(o_d) * IN_SIZE);
            b_addr_d = o_d;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      i_q         <= '0;
      cnt_q       <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      w_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      w_addr_q    <= w_addr_d;
      b_addr_q    <= b_addr_d;
    end
  end

  // Vector buffer contents are meaningless after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    vec_q <= vec_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = b_addr_q;

endmodule

// File: tb/tb_nn_dense_seq.sv
// Bench for nn_dense_seq: two configurations share stimulus; results are compared
// against a table of hand-derived and model-derived expectations.
module tb_nn_dense_seq;
  localparam int unsigned IN_SIZE  = 4;
  localparam int unsigned OUT_SIZE = 2;
  localparam int unsigned NW       = IN_SIZE * OUT_SIZE;
  localparam int unsigned NDIR     = 5;
  localparam int unsigned NRND     = 8;
  localparam int unsigned NV       = NDIR + NRND;

  typedef struct {
    int x  [IN_SIZE];
    int len;
    int w  [NW];
    int b  [OUT_SIZE];
    int e0 [OUT_SIZE];
    int e1 [OUT_SIZE];
    bit bp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, in_last, out_ready;
  logic signed [7:0] in_data;
  logic [2:0] w_addr0, w_addr1;
  logic b_addr0, b_addr1;
  logic signed [7:0] w_data0, w_data1;
  logic signed [23:0] b_data0, b_data1;
  logic in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1, busy0, busy1;
  logic signed [7:0] out_data0;
  logic signed [15:0] out_data1;
  logic out_index0, out_index1;

  logic signed [7:0]  w_rom [NW];
  logic signed [23:0] b_rom [OUT_SIZE];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  vec_t tbl [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROMs: data one cycle after address.
  always @(posedge clk) begin
    w_data0 <= w_rom[w_addr0];
    w_data1 <= w_rom[w_addr1];
    b_data0 <= b_rom[b_addr0];
    b_data1 <= b_rom[b_addr1];
  end

  nn_dense_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(8), .W_W(8), .ACC_W(24),
                 .OUT_W(8), .SHIFT(0), .RELU(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .w_addr(w_addr0), .w_data(w_data0), .b_addr(b_addr0), .b_data(b_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_index(out_index0),
    .out_last(out_last0), .busy(busy0));

  nn_dense_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(8), .W_W(8), .ACC_W(24),
                 .OUT_W(16), .SHIFT(1), .RELU(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .in_last(in_last), .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_index(out_index1),
    .out_last(out_last1), .busy(busy1));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dense layer from first principles: zero-padded dot product, 24-bit wrap, floor shift, clamp.
  function automatic longint model(input vec_t v, input int o, input int shift, input bit relu,
                                   input int outw);
    longint acc, r, hi, lo;
    acc = longint'(v.b[o]);
    for (int i = 0; i < int'(IN_SIZE); i++)
      if (i < v.len) acc += longint'(v.x[i]) * longint'(v.w[o * int'(IN_SIZE) + i]);
    acc = (acc <<< 40) >>> 40;
    r = acc >>> shift;
    if (relu && r < 0) r = 0;
    hi = (longint'(1) <<< (outw - 1)) - 1;
    lo = -hi - 1;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready0"}, longint'(in_ready0), 1);
    chk({tag, "_in_ready1"}, longint'(in_ready1), 1);
    chk({tag, "_out_valid"}, longint'(out_valid0) + longint'(out_valid1), 0);
    chk({tag, "_out_data"}, longint'(out_data0) + longint'(out_data1), 0);
    chk({tag, "_out_index"}, longint'(out_index0) + longint'(out_index1), 0);
    chk({tag, "_out_last"}, longint'(out_last0) + longint'(out_last1), 0);
    chk({tag, "_busy"}, longint'(busy0) + longint'(busy1), 0);
    chk({tag, "_w_addr"}, longint'(w_addr0) + longint'(w_addr1), 0);
    chk({tag, "_b_addr"}, longint'(b_addr0) + longint'(b_addr1), 0);
  endtask

  task automatic load_rom(input vec_t v);
    for (int k = 0; k < int'(NW); k++) w_rom[k] = 8'(v.w[k]);
    for (int k = 0; k < int'(OUT_SIZE); k++) b_rom[k] = 24'(v.b[k]);
  endtask

  // Called at posedge+1; returns the cycle number in which the last element was accepted.
  task automatic send_vec(input vec_t v, output int t_acc);
    bit ok = 1'b0;
    t_acc = cyc;
    for (int n = 0; n < 50 && !ok; n++) begin
      if (in_ready0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("in_ready_timeout", 0, 1);
    for (int e = 0; e < v.len; e++) begin
      in_valid = 1'b1;
      in_data  = 8'(v.x[e]);
      in_last  = (e == v.len - 1);
      t_acc    = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      if (out_valid0) ok = 1'b1;
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int t_acc;
    bit ok;
    logic [2:0] aw;
    string s;
    load_rom(v);
    send_vec(v, t_acc);
    if (v.bp) out_ready = 1'b0;
    for (int n = 0; n < int'(OUT_SIZE); n++) begin
      s = $sformatf("v%0d_n%0d", vi, n);
      wait_valid(ok);
      chk({s, "_valid_timeout"}, longint'(ok), 1);
      if (!ok) begin out_ready = 1'b1; return; end
      if (n == 0) chk({s, "_latency"}, longint'(cyc - t_acc), longint'(IN_SIZE + 2));
      chk({s, "_valid1"}, longint'(out_valid1), 1);
      chk({s, "_data0"}, longint'(out_data0), longint'(v.e0[n]));
      chk({s, "_data1"}, longint'(out_data1), longint'(v.e1[n]));
      chk({s, "_index"}, longint'(out_index0) + longint'(out_index1), longint'(2 * n));
      chk({s, "_last"}, longint'(out_last0) + longint'(out_last1),
          (n == int'(OUT_SIZE) - 1) ? 2 : 0);
      if (v.bp && n == 0) begin
        aw = w_addr0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk({s, "_bp_valid"}, longint'(out_valid0), 1);
          chk({s, "_bp_data"}, longint'(out_data0), longint'(v.e0[0]));
          chk({s, "_bp_index"}, longint'(out_index0), 0);
          chk({s, "_bp_in_ready"}, longint'(in_ready0), 0);
          chk({s, "_bp_w_addr"}, longint'(w_addr0), longint'(aw));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({s, "_bp_release_valid"}, longint'(out_valid0), 1);
      end
      @(posedge clk); #1;
      chk({s, "_valid_drop"}, longint'(out_valid0), 0);
      if (n == int'(OUT_SIZE) - 1) chk({s, "_in_ready_after"}, longint'(in_ready0), 1);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int t_acc, hi;
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    for (int k = 0; k < int'(NW); k++) w_rom[k] = '0;
    for (int k = 0; k < int'(OUT_SIZE); k++) b_rom[k] = '0;

    // Directed table: basic, saturation +/-, early in_last (stale 127s must be zeroed), backpressure.
    tbl[0] = '{'{1, 2, 3, 4}, 4, '{1, 1, 1, 1, -1, -1, -1, -1}, '{5, 0}, '{15, -10}, '{7, 0}, 1'b0};
    tbl[1] = '{'{127, 127, 127, 127}, 4, '{127, 127, 127, 127, 127, 127, 127, 127}, '{0, 0},
               '{127, 127}, '{32258, 32258}, 1'b0};
    tbl[2] = '{'{127, 127, 127, 127}, 4, '{-128, -128, -128, -128, -128, -128, -128, -128},
               '{0, 0}, '{-128, -128}, '{0, 0}, 1'b0};
    tbl[3] = '{'{5, 5, 0, 0}, 2, '{1, 1, 1, 1, 2, 3, 4, 5}, '{0, 0}, '{10, 25}, '{5, 12}, 1'b0};
    tbl[4] = '{'{1, 2, 3, 4}, 4, '{1, 1, 1, 1, -1, -1, -1, -1}, '{5, 0}, '{15, -10}, '{7, 0}, 1'b1};
    for (int r = 0; r < int'(NRND); r++) begin
      for (int i = 0; i < int'(IN_SIZE); i++) v.x[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < int'(NW); i++) v.w[i] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < int'(OUT_SIZE); i++) v.b[i] = int'($urandom_range(8191)) - 4096;
      v.len = int'($urandom_range(IN_SIZE, 1));
      v.bp  = ($urandom_range(3) == 0);
      for (int o = 0; o < int'(OUT_SIZE); o++) begin
        v.e0[o] = int'(model(v, o, 0, 1'b0, 8));
        v.e1[o] = int'(model(v, o, 1, 1'b1, 16));
      end
      tbl[NDIR + r] = v;
    end

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a MAC pass.
    load_rom(tbl[0]);
    send_vec(tbl[0], t_acc);
    @(posedge clk); #1;
    chk("midmac_busy", longint'(busy0), 1);
    chk("midmac_in_ready", longint'(in_ready0), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", longint'(in_ready0), 1);
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid0 || out_valid1) hi++;
    end
    chk("rst_no_out_valid", longint'(hi), 0);
    @(posedge clk); #1;

    for (int vi = 0; vi < int'(NV); vi++) run_vec(tbl[vi], vi);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
